// File: rtl/div_period_meter.sv
// Measures period and high time of a slow signal in clk cycles.
// Results are held in a valid/ack register with sticky overrun and stall flags.
module div_period_meter #(
    parameter int unsigned      CNT_W       = 28,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(16777215)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             meas_ack,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             overrun,
    output logic             stalled
);

    typedef enum logic {SEEK, RUN} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sig_d;
    logic [CNT_W-1:0]       per_cnt;
    logic [CNT_W-1:0]       hi_cnt;

    logic sig_s;
    logic rise;
    logic capture;
    logic ack_ok;

    assign sig_s   = sync[SYNC_STAGES-1];
    assign rise    = sig_s & ~sig_d;
    assign capture = (state == RUN) && rise;
    assign ack_ok  = meas_valid && meas_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEEK;
            sync       <= '0;
            sig_d      <= 1'b0;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], sig_in};
            sig_d <= sig_s;

            case (state)
                SEEK: begin
                    if (rise) begin
                        per_cnt <= CNT_W'(1);
                        hi_cnt  <= CNT_W'(1);
                        state   <= RUN;
                    end else begin
                        per_cnt <= '0;
                        hi_cnt  <= '0;
                    end
                end
                RUN: begin
                    if (rise) begin
                        per_cnt <= CNT_W'(1);
                        hi_cnt  <= CNT_W'(1);
                    end else if (per_cnt == TIMEOUT) begin
                        // No edge within the window: disarm so per_cnt never wraps
                        state   <= SEEK;
                        stalled <= 1'b1;
                        per_cnt <= '0;
                        hi_cnt  <= '0;
                    end else begin
                        per_cnt <= per_cnt + CNT_W'(1);
                        hi_cnt  <= hi_cnt + CNT_W'(sig_s);
                    end
                end
                default: state <= SEEK;
            endcase

            if (capture) begin
                period     <= per_cnt;
                high_time  <= hi_cnt;
                meas_valid <= 1'b1;
                stalled    <= 1'b0;
                if (meas_valid && !meas_ack)
                    overrun <= 1'b1;
            end else if (ack_ok) begin
                meas_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_period_meter.sv
// Directed bench for div_period_meter: a TIMEOUT=100 instance for most scenarios
// and a default-TIMEOUT instance for the long divide-by-256 reset case.
module tb_div_period_meter;

    localparam int CW = 28;

    logic          clk = 1'b0;
    logic          rst;
    logic          sig_in;
    logic          meas_ack;
    logic [CW-1:0] a_period, a_high, b_period, b_high;
    logic          a_valid, a_ovr, a_stall, b_valid, b_ovr, b_stall;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    div_period_meter #(.CNT_W(CW), .SYNC_STAGES(2), .TIMEOUT(28'd100)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .meas_ack(meas_ack),
        .period(a_period), .high_time(a_high), .meas_valid(a_valid),
        .overrun(a_ovr), .stalled(a_stall)
    );

    div_period_meter #(.CNT_W(CW), .SYNC_STAGES(2)) dut_big (
        .clk(clk), .rst(rst), .sig_in(sig_in), .meas_ack(meas_ack),
        .period(b_period), .high_time(b_high), .meas_valid(b_valid),
        .overrun(b_ovr), .stalled(b_stall)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; sig_in = 1'b0; meas_ack = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if ({a_period, a_high, a_valid, a_ovr, a_stall} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got p=%0d h=%0d v=%0b o=%0b s=%0b expected all 0",
                     a_period, a_high, a_valid, a_ovr, a_stall);
        end
        nvec++;
        if ({b_period, b_high, b_valid, b_ovr, b_stall} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs_big: got p=%0d h=%0d v=%0b expected all 0",
                     b_period, b_high, b_valid);
        end
    endtask

    // div-8, each result acked during the low phase
    task automatic test_div8_ack();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            sig_in = 1'b1;
            step(4);
            nvec++;
            if (a_valid !== (k != 0)) begin
                nerr++;
                $display("FAIL div8_valid[%0d]: got %0b expected %0b", k, a_valid, k != 0);
            end
            if (k != 0) begin
                nvec++;
                if (a_period !== 28'd8 || a_high !== 28'd4) begin
                    nerr++;
                    $display("FAIL div8_result[%0d]: got p=%0d h=%0d expected p=8 h=4", k, a_period, a_high);
                end
            end
            sig_in = 1'b0;
            meas_ack = 1'b1;
            step(1);
            meas_ack = 1'b0;
            nvec++;
            if (a_valid !== 1'b0 || a_ovr !== 1'b0) begin
                nerr++;
                $display("FAIL div8_acked[%0d]: got v=%0b o=%0b expected v=0 o=0", k, a_valid, a_ovr);
            end
            step(3);
        end
    endtask

    // div-2, never acked, then a single ack after the input goes quiet
    task automatic test_div2_overrun();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            sig_in = 1'b1; step(1);
            sig_in = 1'b0; step(1);
        end
        step(4);
        nvec++;
        if (a_period !== 28'd2 || a_high !== 28'd1) begin
            nerr++;
            $display("FAIL div2_result: got p=%0d h=%0d expected p=2 h=1", a_period, a_high);
        end
        nvec++;
        if (a_valid !== 1'b1 || a_ovr !== 1'b1) begin
            nerr++;
            $display("FAIL div2_overrun: got v=%0b o=%0b expected v=1 o=1", a_valid, a_ovr);
        end
        meas_ack = 1'b1;
        step(1);
        meas_ack = 1'b0;
        nvec++;
        if (a_valid !== 1'b0 || a_ovr !== 1'b0) begin
            nerr++;
            $display("FAIL div2_ack_clear: got v=%0b o=%0b expected v=0 o=0", a_valid, a_ovr);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            sig_in = 1'b1; step(8);
            sig_in = 1'b0; step(8);
        end
        // third rise: capture edge is 3 clocks after driving high
        sig_in = 1'b1; step(3);
        step(5);
        sig_in = 1'b0;
        step(94);
        nvec++;
        if (a_stall !== 1'b0) begin
            nerr++;
            $display("FAIL timeout_early: got stalled=%0b expected 0 at 99 cycles", a_stall);
        end
        step(1);
        nvec++;
        if (a_stall !== 1'b1) begin
            nerr++;
            $display("FAIL timeout_stall: got stalled=%0b expected 1 at 100 cycles", a_stall);
        end
        nvec++;
        if (a_period !== 28'd16 || a_high !== 28'd8 || a_valid !== 1'b1) begin
            nerr++;
            $display("FAIL timeout_hold: got p=%0d h=%0d v=%0b expected p=16 h=8 v=1", a_period, a_high, a_valid);
        end
        step(20);
        sig_in = 1'b1; step(8);
        nvec++;
        if (a_stall !== 1'b1 || a_period !== 28'd16) begin
            nerr++;
            $display("FAIL timeout_rearm: got stalled=%0b p=%0d expected stalled=1 p=16", a_stall, a_period);
        end
        sig_in = 1'b0; step(8);
        sig_in = 1'b1; step(4);
        nvec++;
        if (a_stall !== 1'b0 || a_period !== 28'd16 || a_high !== 28'd8) begin
            nerr++;
            $display("FAIL timeout_resume: got stalled=%0b p=%0d h=%0d expected 0/16/8", a_stall, a_period, a_high);
        end
        sig_in = 1'b0; step(4);
    endtask

    task automatic test_edge_at_timeout();
        do_reset();
        sig_in = 1'b1; step(50);
        sig_in = 1'b0; step(50);
        sig_in = 1'b1; step(3);
        nvec++;
        if (a_valid !== 1'b1 || a_period !== 28'd100 || a_high !== 28'd50) begin
            nerr++;
            $display("FAIL edge_timeout_capture: got v=%0b p=%0d h=%0d expected 1/100/50", a_valid, a_period, a_high);
        end
        step(1);
        nvec++;
        if (a_stall !== 1'b0) begin
            nerr++;
            $display("FAIL edge_timeout_nostall: got stalled=%0b expected 0", a_stall);
        end
        sig_in = 1'b0; step(4);
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            sig_in = 1'b1; step(128);
            sig_in = 1'b0; step(128);
        end
        sig_in = 1'b1; step(128);
        nvec++;
        if (b_valid !== 1'b1 || b_period !== 28'd256 || b_high !== 28'd128) begin
            nerr++;
            $display("FAIL mid_pre: got v=%0b p=%0d h=%0d expected 1/256/128", b_valid, b_period, b_high);
        end
        sig_in = 1'b0;
        rst = 1'b1; step(1); rst = 1'b0;
        nvec++;
        if ({b_period, b_high, b_valid, b_ovr, b_stall} !== '0) begin
            nerr++;
            $display("FAIL mid_reset: got p=%0d h=%0d v=%0b o=%0b s=%0b expected all 0",
                     b_period, b_high, b_valid, b_ovr, b_stall);
        end
        step(127);
        sig_in = 1'b1; step(128);
        nvec++;
        if (b_valid !== 1'b0) begin
            nerr++;
            $display("FAIL mid_arm_only: got v=%0b expected 0", b_valid);
        end
        sig_in = 1'b0; step(128);
        sig_in = 1'b1; step(4);
        nvec++;
        if (b_valid !== 1'b1 || b_period !== 28'd256 || b_high !== 28'd128) begin
            nerr++;
            $display("FAIL mid_post: got v=%0b p=%0d h=%0d expected 1/256/128", b_valid, b_period, b_high);
        end
        sig_in = 1'b0; step(4);
    endtask

    // div-4 with ack landing on the capture edge
    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            sig_in = 1'b1; step(2);
            sig_in = 1'b0; step(2);
        end
        for (int k = 0; k < 3; k++) begin
            // k=1 skips the ack so overrun sets; k=2 shows ack+capture leaves it set
            sig_in = 1'b1; step(2);
            sig_in = 1'b0;
            meas_ack = (k != 1);
            step(1);
            meas_ack = 1'b0;
            nvec++;
            if (a_valid !== 1'b1 || a_period !== 28'd4 || a_high !== 28'd2) begin
                nerr++;
                $display("FAIL b2b_data[%0d]: got v=%0b p=%0d h=%0d expected 1/4/2", k, a_valid, a_period, a_high);
            end
            nvec++;
            if (a_ovr !== (k != 0)) begin
                nerr++;
                $display("FAIL b2b_overrun[%0d]: got %0b expected %0b", k, a_ovr, k != 0);
            end
            step(1);
        end
    endtask

    initial begin
        test_reset();
        test_div8_ack();
        test_div2_overrun();
        test_timeout();
        test_edge_at_timeout();
        test_reset_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
